// File: rtl/dpram_pkg.sv
// Shared types and the byte-merge helper for the byte-enabled dual-port RAM.
package dpram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST,
        WRITE_FIRST,
        NO_CHANGE
    } wmode_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } seq_state_t;

    // Widest word the merge helper handles; callers zero-extend and truncate around it.
    localparam int unsigned MAX_WIDTH = 256;

    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0]   old_word,
        input logic [MAX_WIDTH-1:0]   new_word,
        input logic [MAX_WIDTH/8-1:0] mask
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_WIDTH / 8; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: walks every address once, writing the fill word, after reset or on request.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT_CLEAR ? CLEAR : IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end
            end
            CLEAR: begin
                if (clear_req) begin
                    addr_d = '0;
                end else if (&addr_q) begin
                    // Last word is written on this edge; busy falls with it.
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign init_busy  = (state_q == CLEAR);
    assign clear_addr = addr_q;

endmodule

// File: rtl/dpram_be_sync.sv
// Single-clock true dual-port RAM with byte enables, per-port write modes, optional
// output register, hardware clear and write/write collision flag.
module dpram_be_sync
    import dpram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter bit                    OUT_REG    = 1'b0,
    parameter wmode_t                WMODE_A    = READ_FIRST,
    parameter wmode_t                WMODE_B    = READ_FIRST,
    parameter bit                    INIT_CLEAR = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ce_a,
    input  logic                    wren_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   address_a,
    input  logic [DATA_WIDTH-1:0]   data_a,
    output logic [DATA_WIDTH-1:0]   q_a,
    output logic                    valid_a,
    input  logic                    ce_b,
    input  logic                    wren_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   address_b,
    input  logic [DATA_WIDTH-1:0]   data_b,
    output logic [DATA_WIDTH-1:0]   q_b,
    output logic                    valid_b,
    input  logic                    clear_req,
    output logic                    init_busy,
    output logic                    collision
);

    localparam int unsigned BE    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE-1:0]         mask
    );
        return DATA_WIDTH'(byte_merge(MAX_WIDTH'(old_word), MAX_WIDTH'(new_word),
                                      (MAX_WIDTH/8)'(mask)));
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] clear_addr;

    dpram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .init_busy  (init_busy),
        .clear_addr (clear_addr)
    );

    logic acc_a, acc_b, wr_a, wr_b;
    assign acc_a = ce_a & ~init_busy;
    assign acc_b = ce_b & ~init_busy;
    assign wr_a  = acc_a & wren_a;
    assign wr_b  = acc_b & wren_b;

    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    assign rd_a = mem[address_a];
    assign rd_b = mem[address_b];

    // Write path A is shared with the sequencer. On a same-address write pair, A's word
    // is built on top of B's merged word so B's non-overlapping bytes survive and A wins
    // the overlap.
    logic                  wa_en;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0] wa_base, wa_word, wb_word;

    always_comb begin
        wb_word = merge(rd_b, data_b, be_b);
        wa_en   = wr_a;
        wa_addr = address_a;
        wa_base = rd_a;
        wa_word = rd_a;
        if (init_busy) begin
            wa_en   = 1'b1;
            wa_addr = clear_addr;
            wa_word = INIT_VALUE;
        end else begin
            if (wr_b && (address_b == address_a)) begin
                wa_base = wb_word;
            end
            wa_word = merge(wa_base, data_a, be_a);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_b) begin
            mem[address_b] <= wb_word;
        end
        if (wa_en) begin
            mem[wa_addr] <= wa_word;
        end
    end

    logic coll_d;
    assign coll_d = wr_a & wr_b & (address_a == address_b) & (|(be_a & be_b));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            collision <= 1'b0;
        end else begin
            collision <= coll_d;
        end
    end

    // First output stage: per-port write-mode selection.
    logic                  load_a, load_b;
    logic [DATA_WIDTH-1:0] next_a, next_b;

    always_comb begin
        load_a = 1'b0;
        next_a = rd_a;
        if (acc_a) begin
            if (!wren_a || (WMODE_A == READ_FIRST)) begin
                load_a = 1'b1;
            end else if (WMODE_A == WRITE_FIRST) begin
                load_a = 1'b1;
                next_a = merge(rd_a, data_a, be_a);
            end
        end
    end

    always_comb begin
        load_b = 1'b0;
        next_b = rd_b;
        if (acc_b) begin
            if (!wren_b || (WMODE_B == READ_FIRST)) begin
                load_b = 1'b1;
            end else if (WMODE_B == WRITE_FIRST) begin
                load_b = 1'b1;
                next_b = merge(rd_b, data_b, be_b);
            end
        end
    end

    logic [DATA_WIDTH-1:0] p1_data_a_q, p1_data_b_q;
    logic                  p1_valid_a_q, p1_valid_b_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_data_a_q  <= '0;
            p1_data_b_q  <= '0;
            p1_valid_a_q <= 1'b0;
            p1_valid_b_q <= 1'b0;
        end else begin
            p1_valid_a_q <= load_a;
            p1_valid_b_q <= load_b;
            if (load_a) begin
                p1_data_a_q <= next_a;
            end
            if (load_b) begin
                p1_data_b_q <= next_b;
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] p2_data_a_q, p2_data_b_q;
        logic                  p2_valid_a_q, p2_valid_b_q;
        logic                  fwd_a, fwd_b;

        // In-flight words are discarded once the sequencer takes over.
        assign fwd_a = p1_valid_a_q & ~init_busy;
        assign fwd_b = p1_valid_b_q & ~init_busy;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                p2_data_a_q  <= '0;
                p2_data_b_q  <= '0;
                p2_valid_a_q <= 1'b0;
                p2_valid_b_q <= 1'b0;
            end else begin
                p2_valid_a_q <= fwd_a;
                p2_valid_b_q <= fwd_b;
                if (fwd_a) begin
                    p2_data_a_q <= p1_data_a_q;
                end
                if (fwd_b) begin
                    p2_data_b_q <= p1_data_b_q;
                end
            end
        end

        assign q_a     = p2_data_a_q;
        assign q_b     = p2_data_b_q;
        assign valid_a = p2_valid_a_q;
        assign valid_b = p2_valid_b_q;
    end else begin : g_no_out_reg
        assign q_a     = p1_data_a_q;
        assign q_b     = p1_data_b_q;
        assign valid_a = p1_valid_a_q;
        assign valid_b = p1_valid_b_q;
    end

endmodule

// File: tb/tb_dpram_be_sync.sv
// Scoreboard bench: dut0 is unregistered (A READ_FIRST, B WRITE_FIRST), dut1 is registered
// (A WRITE_FIRST, B NO_CHANGE); both 16 words deep, filled with A5A5 by the sequencer.
module tb_dpram_be_sync;

    logic clock = 1'b0;
    logic reset_n;

    logic        ce_a [2], wren_a [2], ce_b [2], wren_b [2], clear_req [2];
    logic [1:0]  be_a [2], be_b [2];
    logic [3:0]  address_a [2], address_b [2];
    logic [15:0] data_a [2], data_b [2], q_a [2], q_b [2];
    logic        valid_a [2], valid_b [2], init_busy [2], collision [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected-response queues, one ring per port: index p = 2*dut + (port B ? 1 : 0).
    logic [15:0] sb_data [4][64];
    int          sb_due  [4][64];
    int          wr_ptr  [4];
    int          rd_ptr  [4];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    dpram_be_sync #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .OUT_REG    (1'b0),
        .WMODE_A    (dpram_pkg::READ_FIRST),
        .WMODE_B    (dpram_pkg::WRITE_FIRST),
        .INIT_CLEAR (1'b1),
        .INIT_VALUE (16'hA5A5)
    ) dut0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce_a      (ce_a[0]),
        .wren_a    (wren_a[0]),
        .be_a      (be_a[0]),
        .address_a (address_a[0]),
        .data_a    (data_a[0]),
        .q_a       (q_a[0]),
        .valid_a   (valid_a[0]),
        .ce_b      (ce_b[0]),
        .wren_b    (wren_b[0]),
        .be_b      (be_b[0]),
        .address_b (address_b[0]),
        .data_b    (data_b[0]),
        .q_b       (q_b[0]),
        .valid_b   (valid_b[0]),
        .clear_req (clear_req[0]),
        .init_busy (init_busy[0]),
        .collision (collision[0])
    );

    dpram_be_sync #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .OUT_REG    (1'b1),
        .WMODE_A    (dpram_pkg::WRITE_FIRST),
        .WMODE_B    (dpram_pkg::NO_CHANGE),
        .INIT_CLEAR (1'b1),
        .INIT_VALUE (16'hA5A5)
    ) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce_a      (ce_a[1]),
        .wren_a    (wren_a[1]),
        .be_a      (be_a[1]),
        .address_a (address_a[1]),
        .data_a    (data_a[1]),
        .q_a       (q_a[1]),
        .valid_a   (valid_a[1]),
        .ce_b      (ce_b[1]),
        .wren_b    (wren_b[1]),
        .be_b      (be_b[1]),
        .address_b (address_b[1]),
        .data_b    (data_b[1]),
        .q_b       (q_b[1]),
        .valid_b   (valid_b[1]),
        .clear_req (clear_req[1]),
        .init_busy (init_busy[1]),
        .collision (collision[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic set_port(input int d, input bit pb, input bit we, input logic [1:0] be,
                            input logic [3:0] addr, input logic [15:0] data);
        if (pb) begin
            ce_b[d] = 1'b1; wren_b[d] = we; be_b[d] = be; address_b[d] = addr; data_b[d] = data;
        end else begin
            ce_a[d] = 1'b1; wren_a[d] = we; be_a[d] = be; address_a[d] = addr; data_a[d] = data;
        end
    endtask

    task automatic rd(input int d, input bit pb, input logic [3:0] addr);
        set_port(d, pb, 1'b0, 2'b00, addr, 16'h0000);
    endtask

    task automatic wr(input int d, input bit pb, input logic [1:0] be, input logic [3:0] addr,
                      input logic [15:0] data);
        set_port(d, pb, 1'b1, be, addr, data);
    endtask

    // Expected q for the access being set up now; due on the accepting edge (+1 if registered).
    task automatic push(input int d, input bit pb, input logic [15:0] v);
        int p;
        p = 2 * d + int'(pb);
        sb_data[p][wr_ptr[p] % 64] = v;
        sb_due[p][wr_ptr[p] % 64]  = cyc + ((d == 0) ? 1 : 2);
        wr_ptr[p]++;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            ce_a[d] = 1'b0; wren_a[d] = 1'b0; ce_b[d] = 1'b0; wren_b[d] = 1'b0;
            clear_req[d] = 1'b0;
        end
    endtask

    task automatic wait_clear(input int d, output int n);
        n = 0;
        while (init_busy[d] === 1'b1 && n < 40) begin
            n++;
            cycle();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_q_a%0d", tag, d), 32'(q_a[d]), 32'h0);
            check($sformatf("%s_q_b%0d", tag, d), 32'(q_b[d]), 32'h0);
            check($sformatf("%s_valid_a%0d", tag, d), 32'(valid_a[d]), 32'h0);
            check($sformatf("%s_valid_b%0d", tag, d), 32'(valid_b[d]), 32'h0);
            check($sformatf("%s_collision%0d", tag, d), 32'(collision[d]), 32'h0);
            check($sformatf("%s_init_busy%0d", tag, d), 32'(init_busy[d]), 32'h1);
        end
    endtask

    // Monitor: every valid must match the oldest expected entry on its exact due cycle.
    always @(negedge clock) begin
        logic        v;
        logic [15:0] got;
        int          slot;
        if (reset_n === 1'b1) begin
            for (int p = 0; p < 4; p++) begin
                v    = (p % 2 == 1) ? valid_b[p/2] : valid_a[p/2];
                got  = (p % 2 == 1) ? q_b[p/2] : q_a[p/2];
                slot = rd_ptr[p] % 64;
                if (v === 1'b1) begin
                    if (rd_ptr[p] == wr_ptr[p]) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid port%0d cycle %0d: got q=%h, required no output",
                                 p, cyc, got);
                    end else begin
                        check($sformatf("q_port%0d", p), 32'(got), 32'(sb_data[p][slot]));
                        check($sformatf("latency_port%0d", p), cyc, sb_due[p][slot]);
                        rd_ptr[p]++;
                    end
                end else if (rd_ptr[p] != wr_ptr[p] && sb_due[p][slot] <= cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_valid port%0d cycle %0d: got no valid, required q=%h",
                             p, cyc, sb_data[p][slot]);
                    rd_ptr[p]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wr_ptr[p] = 0;
            rd_ptr[p] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            ce_a[d] = 1'b0; wren_a[d] = 1'b0; be_a[d] = '0; address_a[d] = '0; data_a[d] = '0;
            ce_b[d] = 1'b0; wren_b[d] = 1'b0; be_b[d] = '0; address_b[d] = '0; data_b[d] = '0;
            clear_req[d] = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        wait_clear(0, n);
        check("init_busy_cycles", n, 16);
        check("init_busy_dut1_done", 32'(init_busy[1]), 32'h0);

        // Whole array reads back the fill word on both DUTs.
        for (int i = 0; i < 16; i++) begin
            rd(0, 1'b0, 4'(i)); push(0, 1'b0, 16'hA5A5);
            rd(1, 1'b1, 4'(i)); push(1, 1'b1, 16'hA5A5);
            cycle();
        end
        repeat (3) cycle();

        // Byte mask, READ_FIRST on dut0 A.
        wr(0, 1'b0, 2'b11, 4'd3, 16'h1234); push(0, 1'b0, 16'hA5A5); cycle();
        wr(0, 1'b0, 2'b10, 4'd3, 16'hABCD); push(0, 1'b0, 16'h1234); cycle();
        rd(0, 1'b0, 4'd3);                  push(0, 1'b0, 16'hAB34); cycle();
        // WRITE_FIRST on dut0 B, low-byte mask.
        wr(0, 1'b1, 2'b11, 4'd4, 16'h5678); push(0, 1'b1, 16'h5678); cycle();
        wr(0, 1'b1, 2'b01, 4'd4, 16'hABCD); push(0, 1'b1, 16'h56CD); cycle();
        rd(0, 1'b1, 4'd4);                  push(0, 1'b1, 16'h56CD); cycle();
        // WRITE_FIRST through the output register on dut1 A.
        wr(1, 1'b0, 2'b11, 4'd3, 16'h1234); push(1, 1'b0, 16'h1234); cycle();
        wr(1, 1'b0, 2'b10, 4'd3, 16'hABCD); push(1, 1'b0, 16'hAB34); cycle();
        rd(1, 1'b0, 4'd3);                  push(1, 1'b0, 16'hAB34); cycle();
        repeat (2) cycle();

        // Collision merge on dut0.
        wr(0, 1'b0, 2'b11, 4'd5, 16'h1111); wr(0, 1'b1, 2'b01, 4'd5, 16'h2222);
        push(0, 1'b0, 16'hA5A5); push(0, 1'b1, 16'hA522); cycle();
        check("collision_overlap", 32'(collision[0]), 32'h1);
        rd(0, 1'b0, 4'd5); push(0, 1'b0, 16'h1111); cycle();
        check("collision_one_cycle", 32'(collision[0]), 32'h0);
        wr(0, 1'b0, 2'b10, 4'd5, 16'h1111); wr(0, 1'b1, 2'b01, 4'd5, 16'h2222);
        push(0, 1'b0, 16'h1111); push(0, 1'b1, 16'h1122); cycle();
        check("collision_disjoint", 32'(collision[0]), 32'h0);
        rd(0, 1'b0, 4'd5); push(0, 1'b0, 16'h1122); cycle();
        wr(0, 1'b0, 2'b01, 4'd6, 16'h3333); wr(0, 1'b1, 2'b11, 4'd6, 16'h4444);
        push(0, 1'b0, 16'hA5A5); push(0, 1'b1, 16'h4444); cycle();
        check("collision_partial", 32'(collision[0]), 32'h1);
        rd(0, 1'b1, 4'd6); push(0, 1'b1, 16'h4433); cycle();

        // Cross-port read during write.
        wr(0, 1'b0, 2'b11, 4'd7, 16'h0F0F); push(0, 1'b0, 16'hA5A5); cycle();
        rd(0, 1'b0, 4'd7); wr(0, 1'b1, 2'b11, 4'd7, 16'hF0F0);
        push(0, 1'b0, 16'h0F0F); push(0, 1'b1, 16'hF0F0); cycle();
        check("cross_port_no_collision", 32'(collision[0]), 32'h0);
        rd(0, 1'b0, 4'd7); push(0, 1'b0, 16'hF0F0); cycle();

        // Zero byte enables leave memory untouched.
        wr(0, 1'b0, 2'b11, 4'd12, 16'h1212); push(0, 1'b0, 16'hA5A5); cycle();
        wr(0, 1'b0, 2'b00, 4'd12, 16'hFFFF); wr(0, 1'b1, 2'b00, 4'd12, 16'hEEEE);
        push(0, 1'b0, 16'h1212); push(0, 1'b1, 16'h1212); cycle();
        check("collision_zero_be", 32'(collision[0]), 32'h0);
        rd(0, 1'b0, 4'd12); push(0, 1'b0, 16'h1212); cycle();

        // Registered streaming on dut1.
        wr(1, 1'b0, 2'b11, 4'd0, 16'h1000); push(1, 1'b0, 16'h1000); cycle();
        wr(1, 1'b0, 2'b11, 4'd1, 16'h2001); push(1, 1'b0, 16'h2001); cycle();
        wr(1, 1'b0, 2'b11, 4'd2, 16'h3002); push(1, 1'b0, 16'h3002); cycle();
        rd(1, 1'b0, 4'd0); push(1, 1'b0, 16'h1000); cycle();
        rd(1, 1'b0, 4'd1); push(1, 1'b0, 16'h2001); cycle();
        rd(1, 1'b0, 4'd2); push(1, 1'b0, 16'h3002); cycle();
        repeat (2) cycle();

        // NO_CHANGE write on dut1 B: no valid, q holds the last read.
        wr(1, 1'b1, 2'b11, 4'd8, 16'h4444); cycle();
        repeat (3) cycle();
        check("nochange_hold", 32'(q_b[1]), 32'hA5A5);
        rd(1, 1'b1, 4'd8); push(1, 1'b1, 16'h4444); cycle();
        repeat (2) cycle();

        // clear_req mid-stream: read of address 2 is accepted but must never emerge.
        rd(1, 1'b0, 4'd0); push(1, 1'b0, 16'h1000); cycle();
        rd(1, 1'b0, 4'd1); push(1, 1'b0, 16'h2001); cycle();
        rd(1, 1'b0, 4'd2); clear_req[1] = 1'b1; cycle();
        rd(1, 1'b0, 4'd0); cycle();
        rd(1, 1'b0, 4'd1); cycle();
        wait_clear(1, n);
        check("clear_req_busy_cycles", n, 14);
        rd(1, 1'b0, 4'd2); push(1, 1'b0, 16'hA5A5); cycle();
        repeat (3) cycle();

        // Reset while the sequencer is at address 8.
        clear_req[0] = 1'b1; clear_req[1] = 1'b1; cycle();
        repeat (8) cycle();
        check("busy_before_reset", 32'(init_busy[0]), 32'h1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midclear");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_clear(0, n);
        check("reclear_busy_cycles", n, 16);
        check("reclear_dut1_done", 32'(init_busy[1]), 32'h0);
        rd(0, 1'b0, 4'd12); push(0, 1'b0, 16'hA5A5);
        rd(1, 1'b1, 4'd8);  push(1, 1'b1, 16'hA5A5);
        cycle();
        repeat (3) cycle();

        for (int p = 0; p < 4; p++) begin
            check($sformatf("drained_port%0d", p), rd_ptr[p], wr_ptr[p]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
